// File: rtl/proj_minhash_accum.sv
// MinHash accumulator: NUM_HASH linear hashes per streamed element, running per-lane minimum,
// signature presented through a valid/ready handshake.
module proj_minhash_accum #(
    parameter int FM_BUFFER_SIZE = 16,
    parameter int DATA_W         = 16,
    parameter int HASH_W         = 16,
    parameter int NUM_HASH       = 4,
    parameter int CNT_W          = $clog2(FM_BUFFER_SIZE + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    input  logic [NUM_HASH*HASH_W-1:0]   hash_a,
    input  logic [NUM_HASH*HASH_W-1:0]   hash_b,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            in_data,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic                         busy,
    output logic                         sig_valid,
    input  logic                         sig_ready,
    output logic [NUM_HASH*HASH_W-1:0]   sig_data,
    output logic [CNT_W-1:0]             sig_count
);

    typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, HOLD} state_t;

    state_t                       r_state;
    state_t                       w_next;
    logic [NUM_HASH*HASH_W-1:0]   r_a;
    logic [NUM_HASH*HASH_W-1:0]   r_b;
    logic [NUM_HASH*HASH_W-1:0]   r_p;
    logic [NUM_HASH*HASH_W-1:0]   r_min;
    logic                         r_p_valid;
    logic [CNT_W-1:0]             r_count;
    logic                         r_in_ready;
    logic                         r_busy;
    logic                         r_sig_valid;

    logic [NUM_HASH*HASH_W-1:0]   w_p;
    logic [NUM_HASH*HASH_W-1:0]   w_h;
    logic [NUM_HASH*HASH_W-1:0]   w_min;
    logic                         w_accept;
    logic                         w_at_limit;

    assign w_accept   = in_valid & r_in_ready;
    assign w_at_limit = (r_count == CNT_W'(FM_BUFFER_SIZE - 1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = ACCUM;
            ACCUM:   if (w_accept && (in_last || w_at_limit)) w_next = DRAIN;
            DRAIN:   w_next = HOLD;
            HOLD:    if (sig_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Stage 1 product from the incoming element, stage 2 offset + unsigned min from the registered product.
    always_comb begin
        w_p   = '0;
        w_h   = '0;
        w_min = '0;
        for (int unsigned k = 0; k < NUM_HASH; k++) begin
            w_p[k*HASH_W +: HASH_W] = HASH_W'({{DATA_W{1'b0}}, r_a[k*HASH_W +: HASH_W]}
                                             * {{HASH_W{1'b0}}, in_data});
            w_h[k*HASH_W +: HASH_W] = r_p[k*HASH_W +: HASH_W] + r_b[k*HASH_W +: HASH_W];
            w_min[k*HASH_W +: HASH_W] = (w_h[k*HASH_W +: HASH_W] < r_min[k*HASH_W +: HASH_W])
                                        ? w_h[k*HASH_W +: HASH_W] : r_min[k*HASH_W +: HASH_W];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_p         <= '0;
            r_min       <= '1;
            r_p_valid   <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b0;
            r_busy      <= 1'b0;
            r_sig_valid <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == ACCUM);
            r_busy      <= (w_next != IDLE);
            r_sig_valid <= (w_next == HOLD);
            if (r_state == IDLE && start) begin
                r_a       <= hash_a;
                r_b       <= hash_b;
                r_min     <= '1;
                r_count   <= '0;
                r_p_valid <= 1'b0;
            end else begin
                r_p_valid <= w_accept;
                if (w_accept) begin
                    r_p     <= w_p;
                    r_count <= r_count + CNT_W'(1);
                end
                if (r_p_valid) r_min <= w_min;
            end
        end
    end

    assign in_ready  = r_in_ready;
    assign busy      = r_busy;
    assign sig_valid = r_sig_valid;
    assign sig_data  = r_min;
    assign sig_count = r_count;

endmodule

// File: tb/tb_proj_minhash_accum.sv
// Directed bench for proj_minhash_accum: 2 lanes of 8 bits, 8-bit data, run limit of 4 elements.
module tb_proj_minhash_accum;

    localparam int NH = 2;
    localparam int HW = 8;
    localparam int DW = 8;
    localparam int FB = 4;
    localparam int CW = $clog2(FB + 1);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [NH*HW-1:0]  hash_a = '0;
    logic [NH*HW-1:0]  hash_b = '0;
    logic              in_valid = 1'b0;
    logic [DW-1:0]     in_data = '0;
    logic              in_last = 1'b0;
    logic              in_ready;
    logic              busy;
    logic              sig_valid;
    logic              sig_ready = 1'b0;
    logic [NH*HW-1:0]  sig_data;
    logic [CW-1:0]     sig_count;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;

    localparam logic [NH*HW-1:0] A0 = {8'd5, 8'd3};
    localparam logic [NH*HW-1:0] B0 = {8'd7, 8'd1};

    proj_minhash_accum #(
        .FM_BUFFER_SIZE(FB),
        .DATA_W(DW),
        .HASH_W(HW),
        .NUM_HASH(NH)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .hash_a(hash_a), .hash_b(hash_b),
        .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
        .busy(busy), .sig_valid(sig_valid), .sig_ready(sig_ready),
        .sig_data(sig_data), .sig_count(sig_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [NH*HW-1:0] a, input logic [NH*HW-1:0] b);
        hash_a = a;
        hash_b = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic feed(input logic [DW-1:0] x, input logic last);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = x;
        in_last  = last;
        for (int i = 0; i < 20 && !ok; i++) begin
            ok = in_ready;
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL feed_timeout: in_ready=%0b required 1 within 20 cycles", in_ready);
        end
    endtask

    task automatic wait_hold();
        bit ok;
        ok = sig_valid;
        for (int i = 0; i < 20 && !ok; i++) begin
            tick();
            ok = sig_valid;
        end
        if (!ok) begin
            n_vec++;
            n_bad++;
            $display("FAIL hold_timeout: sig_valid=%0b required 1 within 20 cycles", sig_valid);
        end
    endtask

    task automatic release_sig();
        sig_ready = 1'b1;
        tick();
        sig_ready = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        n_vec++; if (busy !== 1'b0)      begin n_bad++; $display("FAIL rst_busy: got %0b want 0", busy); end
        n_vec++; if (sig_valid !== 1'b0) begin n_bad++; $display("FAIL rst_sig_valid: got %0b want 0", sig_valid); end
        n_vec++; if (sig_data !== 16'hFFFF) begin n_bad++; $display("FAIL rst_sig_data: got %h want ffff", sig_data); end
        n_vec++; if (sig_count !== 3'd0) begin n_bad++; $display("FAIL rst_sig_count: got %0d want 0", sig_count); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        do_start(A0, B0);
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_ready_after_start: got %0b want 1", in_ready); end
        n_vec++; if (busy !== 1'b1)     begin n_bad++; $display("FAIL basic_busy: got %0b want 1", busy); end
        feed(8'd2, 1'b0);
        feed(8'd100, 1'b0);
        feed(8'd4, 1'b1);
        n_vec++; if (sig_valid !== 1'b0) begin n_bad++; $display("FAIL basic_valid_early: got %0b want 0", sig_valid); end
        n_vec++; if (in_ready !== 1'b0)  begin n_bad++; $display("FAIL basic_ready_drain: got %0b want 0", in_ready); end
        tick();
        n_vec++; if (sig_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid_latency: got %0b want 1", sig_valid); end
        n_vec++; if (sig_data !== {8'd17, 8'd7}) begin n_bad++; $display("FAIL basic_sig_data: got %h want %h", sig_data, {8'd17, 8'd7}); end
        n_vec++; if (sig_count !== 3'd3) begin n_bad++; $display("FAIL basic_sig_count: got %0d want 3", sig_count); end
        release_sig();
        n_vec++; if (busy !== 1'b0 || sig_valid !== 1'b0) begin n_bad++; $display("FAIL basic_idle: busy=%0b valid=%0b want 0 0", busy, sig_valid); end
        n_vec++; if (sig_data !== {8'd17, 8'd7}) begin n_bad++; $display("FAIL basic_idle_data: got %h want %h", sig_data, {8'd17, 8'd7}); end
    endtask

    task automatic test_wrap();
        do_start(A0, B0);
        feed(8'd85, 1'b1);
        wait_hold();
        // lane0 = 3*85+1 = 256 -> 0 ; lane1 = 5*85+7 = 432 -> 176
        n_vec++; if (sig_data !== {8'd176, 8'd0}) begin n_bad++; $display("FAIL wrap_sig_data: got %h want %h", sig_data, {8'd176, 8'd0}); end
        n_vec++; if (sig_count !== 3'd1) begin n_bad++; $display("FAIL wrap_sig_count: got %0d want 1", sig_count); end
        release_sig();
    endtask

    task automatic test_all_ones();
        do_start(A0, B0);
        feed(8'd170, 1'b1);
        wait_hold();
        // lane0 = 3*170+1 = 511 -> 255 (equal to init, unchanged) ; lane1 = 857 -> 89
        n_vec++; if (sig_data !== {8'd89, 8'd255}) begin n_bad++; $display("FAIL allones_sig_data: got %h want %h", sig_data, {8'd89, 8'd255}); end
        release_sig();
    endtask

    task automatic test_backpressure();
        do_start(A0, B0);
        feed(8'd2, 1'b1);
        wait_hold();
        for (int i = 0; i < 5; i++) begin
            in_valid = i[0];
            start    = ~i[0];
            in_data  = 8'd0;
            tick();
            n_vec++;
            if (sig_valid !== 1'b1 || in_ready !== 1'b0 || sig_data !== {8'd17, 8'd7} || sig_count !== 3'd1) begin
                n_bad++;
                $display("FAIL bp_hold: valid=%0b ready=%0b data=%h cnt=%0d want 1 0 %h 1",
                         sig_valid, in_ready, sig_data, sig_count, {8'd17, 8'd7});
            end
        end
        in_valid  = 1'b0;
        sig_ready = 1'b1;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        sig_ready = 1'b0;
        n_vec++; if (busy !== 1'b0 || sig_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: busy=%0b valid=%0b want 0 0", busy, sig_valid); end
        tick();
        n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL bp_start_ignored: busy=%0b want 0", busy); end
    endtask

    task automatic test_auto_term();
        logic [DW-1:0] v [6];
        int unsigned acc;
        v = '{8'd40, 8'd3, 8'd9, 8'd20, 8'd0, 8'd0};
        acc = 0;
        do_start(A0, B0);
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            in_data  = v[i];
            if (in_ready) acc++;
            tick();
        end
        in_valid = 1'b0;
        n_vec++; if (acc != 4) begin n_bad++; $display("FAIL auto_accepted: got %0d want 4", acc); end
        n_vec++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL auto_ready: got %0b want 0", in_ready); end
        wait_hold();
        n_vec++; if (sig_data !== {8'd22, 8'd10}) begin n_bad++; $display("FAIL auto_sig_data: got %h want %h", sig_data, {8'd22, 8'd10}); end
        n_vec++; if (sig_count !== 3'd4) begin n_bad++; $display("FAIL auto_sig_count: got %0d want 4", sig_count); end
        release_sig();
    endtask

    task automatic test_bubbles();
        do_start(A0, B0);
        hash_a = {8'd9, 8'd11};
        hash_b = {8'd0, 8'd0};
        feed(8'd2, 1'b0);
        tick();
        feed(8'd100, 1'b0);
        tick();
        feed(8'd4, 1'b1);
        wait_hold();
        n_vec++; if (sig_data !== {8'd17, 8'd7}) begin n_bad++; $display("FAIL bubble_sig_data: got %h want %h", sig_data, {8'd17, 8'd7}); end
        n_vec++; if (sig_count !== 3'd3) begin n_bad++; $display("FAIL bubble_sig_count: got %0d want 3", sig_count); end
        release_sig();
    endtask

    task automatic test_reset_midrun();
        do_start(A0, B0);
        feed(8'd2, 1'b0);
        feed(8'd100, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (in_ready !== 1'b0 || busy !== 1'b0 || sig_valid !== 1'b0 || sig_data !== 16'hFFFF || sig_count !== 3'd0) begin
            n_bad++;
            $display("FAIL midrun_reset: ready=%0b busy=%0b valid=%0b data=%h cnt=%0d want 0 0 0 ffff 0",
                     in_ready, busy, sig_valid, sig_data, sig_count);
        end
        #1;
        rst_n = 1'b1;
        tick();
        do_start(A0, B0);
        feed(8'd60, 1'b1);
        wait_hold();
        n_vec++; if (sig_data !== {8'd51, 8'd181}) begin n_bad++; $display("FAIL midrun_sig_data: got %h want %h", sig_data, {8'd51, 8'd181}); end
        n_vec++; if (sig_count !== 3'd1) begin n_bad++; $display("FAIL midrun_sig_count: got %0d want 1", sig_count); end
        release_sig();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap();
        test_all_ones();
        test_backpressure();
        test_auto_term();
        test_bubbles();
        test_reset_midrun();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
